axis_mem_arbiter: RTL and testbench

- Round-robin arbiter that shares the single AXI-Stream write port of memory_controller among NUM_PORTS requesters.
- Arbitrates per packet: a grant is held from the first beat until tlast, so beats from different requesters never interleave at the memory controller.
- Drives one registered AXI-Stream master output stage.
- Guards against runaway packets with a beat limit.

---
 rtl/memory_arb_pkg.sv | 44 ++++
 rtl/rr_arbiter.sv | 17 +
 rtl/axis_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_axis_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arb_pkg.sv
// Shared types and helpers for the memory-port arbiters.
package memory_arb_pkg;

    // Upper bound on requesters any arbiter in this family supports.
    localparam int MAX_PORTS = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Width of a counter that must hold values 0..max_beats.
    function automatic int beat_cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

    // Round-robin pick: first set request bit scanning from (last+1) mod n,
    // wrapping around. Returns 0 when no request is set (callers gate with any_req).
    function automatic logic [MAX_IDX_W-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input logic [MAX_IDX_W-1:0] last,
        input int                   n
    );
        logic [MAX_IDX_W-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = '0;
        found = 1'b0;
        for (int off = 1; off <= MAX_PORTS; off++) begin
            // last < n and off <= n, so a single subtraction implements the wrap.
            idx = int'(last) + off;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (off <= n && !found && req[idx[MAX_IDX_W-1:0]]) begin
                pick  = idx[MAX_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin request picker, shared by the write- and read-side arbiters.
module rr_arbiter
    import memory_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 any_req
);

    assign any_req   = |req;
    assign grant_idx = IDX_W'(rr_pick(MAX_PORTS'(req), MAX_IDX_W'(last_grant), NUM_PORTS));

endmodule

// File: rtl/axis_mem_arbiter.sv
// Packet-level round-robin arbiter in front of the memory controller's
// AXI-Stream write port, with a registered output stage and a beat limit
// that cuts off runaway packets.
module axis_mem_arbiter
    import memory_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,   // 2..8
    parameter int MAX_BEATS  = 16
) (
    input  logic                                axis_aclk,
    input  logic                                axis_aresetn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] s_axis_tstrb,
    input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                s_axis_tlast,
    output logic [NUM_PORTS-1:0]                s_axis_tready,
    output logic [DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]             m_axis_tstrb,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,
    output logic                                grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0]        grant_idx,
    output logic                                pkt_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_PORTS);
    localparam int CNT_W  = beat_cnt_width(MAX_BEATS);

    arb_state_t              state_reg,       state_next;
    logic [IDX_W-1:0]        grant_idx_reg,   grant_idx_next;
    logic                    grant_valid_reg, grant_valid_next;
    logic [IDX_W-1:0]        last_grant_reg,  last_grant_next;
    logic [CNT_W-1:0]        beat_cnt_reg,    beat_cnt_next;
    logic [DATA_WIDTH-1:0]   m_tdata_reg,     m_tdata_next;
    logic [STRB_W-1:0]       m_tstrb_reg,     m_tstrb_next;
    logic                    m_tvalid_reg,    m_tvalid_next;
    logic                    m_tlast_reg,     m_tlast_next;
    logic                    pkt_err_reg,     pkt_err_next;

    logic [DATA_WIDTH-1:0]   tdata_arr [NUM_PORTS];
    logic [STRB_W-1:0]       tstrb_arr [NUM_PORTS];

    logic [IDX_W-1:0]        rr_idx;
    logic                    rr_any;
    logic                    out_ready;
    logic                    port_ready;
    logic                    accept;
    logic                    limit_hit;
    logic                    pkt_end;
    logic                    sel_tlast;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .req        (s_axis_tvalid),
        .last_grant (last_grant_reg),
        .grant_idx  (rr_idx),
        .any_req    (rr_any)
    );

    // Unflatten requester buses and fan the shared ready out to the granted port only.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign tdata_arr[gi]     = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign tstrb_arr[gi]     = s_axis_tstrb[gi*STRB_W +: STRB_W];
            assign s_axis_tready[gi] = port_ready & (grant_idx_reg == IDX_W'(gi));
        end
    endgenerate

    // The output slot can take a beat when empty or when it drains this cycle.
    assign out_ready  = ~m_tvalid_reg | m_axis_tready;
    assign port_ready = (state_reg == ARB_BUSY) & out_ready;
    assign sel_tlast  = s_axis_tlast[grant_idx_reg];
    assign accept     = port_ready & s_axis_tvalid[grant_idx_reg];
    // Beat number MAX_BEATS without tlast: terminate the packet on this beat.
    assign limit_hit  = accept & ~sel_tlast & (beat_cnt_reg == CNT_W'(MAX_BEATS - 1));
    assign pkt_end    = accept & (sel_tlast | limit_hit);

    // Next-state, grant bookkeeping and output-stage loading.
    always_comb begin
        state_next       = state_reg;
        grant_idx_next   = grant_idx_reg;
        grant_valid_next = grant_valid_reg;
        last_grant_next  = last_grant_reg;
        beat_cnt_next    = beat_cnt_reg;
        m_tdata_next     = m_tdata_reg;
        m_tstrb_next     = m_tstrb_reg;
        m_tvalid_next    = m_tvalid_reg;
        m_tlast_next     = m_tlast_reg;
        pkt_err_next     = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                if (rr_any) begin
                    grant_idx_next   = rr_idx;
                    grant_valid_next = 1'b1;
                    beat_cnt_next    = '0;
                    state_next       = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (pkt_end) begin
                    last_grant_next  = grant_idx_reg;
                    grant_valid_next = 1'b0;
                    beat_cnt_next    = '0;
                    pkt_err_next     = limit_hit;
                    state_next       = ARB_IDLE;
                end else if (accept) begin
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase

        if (accept) begin
            m_tdata_next  = tdata_arr[grant_idx_reg];
            m_tstrb_next  = tstrb_arr[grant_idx_reg];
            m_tlast_next  = sel_tlast | limit_hit;
            m_tvalid_next = 1'b1;
        end else if (m_axis_tready) begin
            m_tvalid_next = 1'b0;
        end
    end

    // State register; reset discards any in-flight beat and restores port-0 priority.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_reg       <= ARB_IDLE;
            grant_idx_reg   <= '0;
            grant_valid_reg <= 1'b0;
            last_grant_reg  <= IDX_W'(NUM_PORTS - 1);
            beat_cnt_reg    <= '0;
            m_tdata_reg     <= '0;
            m_tstrb_reg     <= '0;
            m_tvalid_reg    <= 1'b0;
            m_tlast_reg     <= 1'b0;
            pkt_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_idx_reg   <= grant_idx_next;
            grant_valid_reg <= grant_valid_next;
            last_grant_reg  <= last_grant_next;
            beat_cnt_reg    <= beat_cnt_next;
            m_tdata_reg     <= m_tdata_next;
            m_tstrb_reg     <= m_tstrb_next;
            m_tvalid_reg    <= m_tvalid_next;
            m_tlast_reg     <= m_tlast_next;
            pkt_err_reg     <= pkt_err_next;
        end
    end

    assign m_axis_tdata  = m_tdata_reg;
    assign m_axis_tstrb  = m_tstrb_reg;
    assign m_axis_tvalid = m_tvalid_reg;
    assign m_axis_tlast  = m_tlast_reg;
    assign grant_valid   = grant_valid_reg;
    assign grant_idx     = grant_idx_reg;
    assign pkt_err       = pkt_err_reg;

endmodule

// File: tb/tb_axis_mem_arbiter.sv
// Directed bench for axis_mem_arbiter (4 ports, beat limit 4).
module tb_axis_mem_arbiter;

    localparam int DW = 32;
    localparam int NP = 4;
    localparam int SW = DW / 8;
    localparam int MB = 4;

    logic              axis_aclk = 1'b0;
    logic              axis_aresetn;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP*SW-1:0]  s_axis_tstrb;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [SW-1:0]     m_axis_tstrb;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic              pkt_err;

    axis_mem_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .MAX_BEATS  (MB)
    ) dut (
        .axis_aclk     (axis_aclk),
        .axis_aresetn  (axis_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .pkt_err       (pkt_err)
    );

    always #5 axis_aclk = ~axis_aclk;

    int n_vec = 0;
    int n_err = 0;

    // Per-port beat sources.
    logic [DW-1:0] src_data [NP][32];
    logic          src_last [NP][32];
    int            src_cnt  [NP];
    int            src_rd   [NP];
    logic [NP-1:0] hold;

    // Observed output beats and grant events.
    logic [DW-1:0] out_data [$];
    logic          out_last [$];
    logic [SW-1:0] out_strb [$];
    int            grant_log [$];
    int            err_pulses;
    logic          gv_prev;

    // Each requester drives its data's low nibble as strobe (so xxxx0 data gives a zero strobe).
    function automatic logic [SW-1:0] strb_of(input logic [DW-1:0] d);
        return d[SW-1:0];
    endfunction

    task automatic push_beat(input int p, input logic [DW-1:0] d, input logic l);
        src_data[p][src_cnt[p]] = d;
        src_last[p][src_cnt[p]] = l;
        src_cnt[p]++;
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < NP; p++) begin
            if (!hold[p] && src_rd[p] < src_cnt[p]) begin
                s_axis_tvalid[p]          = 1'b1;
                s_axis_tdata[p*DW +: DW]  = src_data[p][src_rd[p]];
                s_axis_tstrb[p*SW +: SW]  = strb_of(src_data[p][src_rd[p]]);
                s_axis_tlast[p]           = src_last[p][src_rd[p]];
            end else begin
                s_axis_tvalid[p]          = 1'b0;
                s_axis_tdata[p*DW +: DW]  = '0;
                s_axis_tstrb[p*SW +: SW]  = '0;
                s_axis_tlast[p]           = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes at the falling edge, advance after the rising edge.
    task automatic tick();
        logic [NP-1:0] hs;
        logic          mhs;
        logic [DW-1:0] d;
        logic [SW-1:0] st;
        logic          l;
        #4;
        hs  = s_axis_tvalid & s_axis_tready;
        mhs = m_axis_tvalid & m_axis_tready;
        d   = m_axis_tdata;
        st  = m_axis_tstrb;
        l   = m_axis_tlast;
        @(posedge axis_aclk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) src_rd[p]++;
        end
        if (mhs) begin
            out_data.push_back(d);
            out_strb.push_back(st);
            out_last.push_back(l);
        end
        if (grant_valid && !gv_prev) grant_log.push_back(int'(grant_idx));
        gv_prev = grant_valid;
        if (pkt_err) err_pulses++;
        drive_inputs();
    endtask

    function automatic bit pending();
        for (int p = 0; p < NP; p++) begin
            if (src_rd[p] < src_cnt[p]) return 1'b1;
        end
        return m_axis_tvalid || grant_valid;
    endfunction

    task automatic drain(input string name);
        int k = 0;
        while (pending() && k < 200) begin
            tick();
            k++;
        end
        n_vec++;
        if (pending()) begin
            n_err++;
            $display("FAIL %s drain: still busy after %0d cycles, required idle", name, k);
        end
    endtask

    task automatic clear_logs();
        out_data.delete();
        out_last.delete();
        out_strb.delete();
        grant_log.delete();
        err_pulses = 0;
        gv_prev    = 1'b0;
    endtask

    task automatic apply_reset();
        axis_aresetn  = 1'b0;
        for (int p = 0; p < NP; p++) begin
            src_cnt[p] = 0;
            src_rd[p]  = 0;
        end
        hold          = '0;
        m_axis_tready = 1'b1;
        drive_inputs();
        repeat (2) @(posedge axis_aclk);
        #1;
        axis_aresetn = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        apply_reset();
        // Request present during reset must not be served while reset is held.
        axis_aresetn = 1'b0;
        push_beat(1, 32'hDEAD_0001, 1'b1);
        drive_inputs();
        repeat (2) @(posedge axis_aclk);
        #1;
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset m_tvalid: got %b expected 0", m_axis_tvalid); end
        n_vec++; if (m_axis_tdata !== '0) begin n_err++; $display("FAIL reset m_tdata: got %h expected 0", m_axis_tdata); end
        n_vec++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset m_tlast: got %b expected 0", m_axis_tlast); end
        n_vec++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL reset grant_valid: got %b expected 0", grant_valid); end
        n_vec++; if (grant_idx !== 2'd0) begin n_err++; $display("FAIL reset grant_idx: got %0d expected 0", grant_idx); end
        n_vec++; if (pkt_err !== 1'b0) begin n_err++; $display("FAIL reset pkt_err: got %b expected 0", pkt_err); end
        n_vec++; if (s_axis_tready !== 4'b0000) begin n_err++; $display("FAIL reset tready: got %b expected 0000", s_axis_tready); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        apply_reset();
        push_beat(1, 32'h1111_0001, 1'b0);
        push_beat(1, 32'h1111_0002, 1'b0);
        push_beat(1, 32'h1111_0000, 1'b1);
        drive_inputs();
        n_vec++; if (s_axis_tready !== 4'b0000) begin n_err++; $display("FAIL single idle_tready: got %b expected 0000", s_axis_tready); end
        tick();
        n_vec++; if (grant_valid !== 1'b1 || grant_idx !== 2'd1) begin n_err++; $display("FAIL single grant: got v=%b idx=%0d expected v=1 idx=1", grant_valid, grant_idx); end
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL single early_tvalid: got %b expected 0", m_axis_tvalid); end
        n_vec++; if (s_axis_tready !== 4'b0010) begin n_err++; $display("FAIL single busy_tready: got %b expected 0010", s_axis_tready); end
        tick();
        n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h1111_0001 || m_axis_tlast !== 1'b0 || m_axis_tstrb !== 4'h1) begin
            n_err++; $display("FAIL single beat1: got v=%b d=%h l=%b s=%h expected v=1 d=11110001 l=0 s=1", m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tstrb); end
        tick();
        n_vec++; if (m_axis_tdata !== 32'h1111_0002 || m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL single beat2: got d=%h l=%b expected d=11110002 l=0", m_axis_tdata, m_axis_tlast); end
        tick();
        n_vec++; if (m_axis_tdata !== 32'h1111_0000 || m_axis_tlast !== 1'b1 || m_axis_tstrb !== 4'h0 || m_axis_tvalid !== 1'b1) begin
            n_err++; $display("FAIL single beat3: got v=%b d=%h l=%b s=%h expected v=1 d=11110000 l=1 s=0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tstrb); end
        n_vec++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL single grant_drop: got %b expected 0", grant_valid); end
        tick();
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL single tvalid_clear: got %b expected 0", m_axis_tvalid); end
        n_vec++; if (out_data.size() != 3 || grant_log.size() != 1) begin n_err++; $display("FAIL single counts: got beats=%0d grants=%0d expected 3 and 1", out_data.size(), grant_log.size()); end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_d [8];
        logic          exp_l [8];
        int            exp_g [4];
        apply_reset();
        push_beat(0, 32'hA000_0011, 1'b0); push_beat(0, 32'hA000_0012, 1'b1);
        push_beat(0, 32'hA000_0021, 1'b0); push_beat(0, 32'hA000_0022, 1'b1);
        push_beat(2, 32'hC000_0011, 1'b0); push_beat(2, 32'hC000_0012, 1'b1);
        push_beat(2, 32'hC000_0021, 1'b0); push_beat(2, 32'hC000_0022, 1'b1);
        drive_inputs();
        drain("rr");
        exp_g = '{0, 2, 0, 2};
        exp_d = '{32'hA000_0011, 32'hA000_0012, 32'hC000_0011, 32'hC000_0012,
                  32'hA000_0021, 32'hA000_0022, 32'hC000_0021, 32'hC000_0022};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        n_vec++; if (grant_log.size() != 4) begin n_err++; $display("FAIL rr grant_count: got %0d expected 4", grant_log.size()); end
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            n_vec++; if (grant_log[i] != exp_g[i]) begin n_err++; $display("FAIL rr grant[%0d]: got %0d expected %0d", i, grant_log[i], exp_g[i]); end
        end
        n_vec++; if (out_data.size() != 8) begin n_err++; $display("FAIL rr beat_count: got %0d expected 8", out_data.size()); end
        for (int i = 0; i < 8 && i < out_data.size(); i++) begin
            n_vec++; if (out_data[i] !== exp_d[i] || out_last[i] !== exp_l[i]) begin
                n_err++; $display("FAIL rr beat[%0d]: got d=%h l=%b expected d=%h l=%b", i, out_data[i], out_last[i], exp_d[i], exp_l[i]); end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure();
        apply_reset();
        push_beat(1, 32'h2222_0001, 1'b0);
        push_beat(1, 32'h2222_0002, 1'b0);
        push_beat(1, 32'h2222_0003, 1'b1);
        drive_inputs();
        tick();
        tick();
        m_axis_tready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h2222_0001) begin
                n_err++; $display("FAIL bp hold[%0d]: got v=%b d=%h expected v=1 d=22220001", c, m_axis_tvalid, m_axis_tdata); end
            n_vec++; if (s_axis_tready[1] !== 1'b0) begin n_err++; $display("FAIL bp tready[%0d]: got %b expected 0", c, s_axis_tready[1]); end
        end
        m_axis_tready = 1'b1;
        drain("bp");
        n_vec++; if (out_data.size() != 3) begin n_err++; $display("FAIL bp beat_count: got %0d expected 3", out_data.size()); end
        for (int i = 0; i < 3 && i < out_data.size(); i++) begin
            n_vec++; if (out_data[i] !== 32'h2222_0001 + DW'(i) || out_last[i] !== (i == 2)) begin
                n_err++; $display("FAIL bp beat[%0d]: got d=%h l=%b expected d=%h l=%b", i, out_data[i], out_last[i], 32'h2222_0001 + DW'(i), (i == 2)); end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_beat_limit();
        logic exp_l [6];
        apply_reset();
        for (int b = 1; b <= 6; b++) push_beat(3, 32'h3333_0000 + DW'(b), b == 6);
        drive_inputs();
        drain("limit");
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        n_vec++; if (out_data.size() != 6) begin n_err++; $display("FAIL limit beat_count: got %0d expected 6", out_data.size()); end
        for (int i = 0; i < 6 && i < out_data.size(); i++) begin
            n_vec++; if (out_data[i] !== 32'h3333_0001 + DW'(i) || out_last[i] !== exp_l[i]) begin
                n_err++; $display("FAIL limit beat[%0d]: got d=%h l=%b expected d=%h l=%b", i, out_data[i], out_last[i], 32'h3333_0001 + DW'(i), exp_l[i]); end
        end
        n_vec++; if (err_pulses != 1) begin n_err++; $display("FAIL limit pkt_err: got %0d pulse cycles expected 1", err_pulses); end
        n_vec++; if (grant_log.size() != 2) begin n_err++; $display("FAIL limit grants: got %0d expected 2", grant_log.size()); end
        $display("test_beat_limit done");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        push_beat(1, 32'h4444_0001, 1'b0);
        push_beat(1, 32'h4444_0002, 1'b0);
        push_beat(1, 32'h4444_0003, 1'b1);
        drive_inputs();
        tick();
        tick();
        #2;
        axis_aresetn = 1'b0;
        #1;
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid m_tvalid: got %b expected 0", m_axis_tvalid); end
        n_vec++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL rstmid grant_valid: got %b expected 0", grant_valid); end
        apply_reset();
        push_beat(0, 32'h5555_0001, 1'b1);
        push_beat(1, 32'h6666_0001, 1'b0);
        push_beat(1, 32'h6666_0002, 1'b1);
        drive_inputs();
        drain("rstmid");
        n_vec++; if (grant_log.size() != 2 || grant_log[0] != 0) begin
            n_err++; $display("FAIL rstmid first_grant: got count=%0d first=%0d expected count=2 first=0", grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1); end
        n_vec++; if (out_data.size() != 3 || out_data[0] !== 32'h5555_0001) begin
            n_err++; $display("FAIL rstmid beats: got count=%0d expected 3 starting 55550001", out_data.size()); end
        $display("test_reset_mid done");
    endtask

    task automatic test_hold_grant();
        logic [DW-1:0] exp_d [4];
        logic          exp_l [4];
        apply_reset();
        push_beat(2, 32'h7777_0001, 1'b0);
        push_beat(2, 32'h7777_0002, 1'b0);
        push_beat(2, 32'h7777_0003, 1'b1);
        drive_inputs();
        tick();
        n_vec++; if (grant_idx !== 2'd2 || grant_valid !== 1'b1) begin n_err++; $display("FAIL hold grant: got v=%b idx=%0d expected v=1 idx=2", grant_valid, grant_idx); end
        push_beat(0, 32'h8888_0001, 1'b1);
        drive_inputs();
        tick();
        hold[2] = 1'b1;
        drive_inputs();
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (grant_idx !== 2'd2 || grant_valid !== 1'b1) begin
                n_err++; $display("FAIL hold keep[%0d]: got v=%b idx=%0d expected v=1 idx=2", c, grant_valid, grant_idx); end
            n_vec++; if (s_axis_tready[0] !== 1'b0) begin n_err++; $display("FAIL hold p0_ready[%0d]: got %b expected 0", c, s_axis_tready[0]); end
        end
        hold[2] = 1'b0;
        drive_inputs();
        drain("hold");
        exp_d = '{32'h7777_0001, 32'h7777_0002, 32'h7777_0003, 32'h8888_0001};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
        n_vec++; if (out_data.size() != 4) begin n_err++; $display("FAIL hold beat_count: got %0d expected 4", out_data.size()); end
        for (int i = 0; i < 4 && i < out_data.size(); i++) begin
            n_vec++; if (out_data[i] !== exp_d[i] || out_last[i] !== exp_l[i]) begin
                n_err++; $display("FAIL hold beat[%0d]: got d=%h l=%b expected d=%h l=%b", i, out_data[i], out_last[i], exp_d[i], exp_l[i]); end
        end
        $display("test_hold_grant done");
    endtask

    initial begin
        axis_aresetn  = 1'b0;
        m_axis_tready = 1'b1;
        hold          = '0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tlast  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_beat_limit();
        test_reset_mid();
        test_hold_grant();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
